store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_pkg.sv | 21 ++
 rtl/sb_fwd_match.sv | 31 +++
 rtl/store_buffer.sv | 142 ++++++++++++++
 tb/tb_store_buffer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared types and constants for the store buffer
package store_buffer_pkg;

  localparam int SB_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } sb_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } sb_state_t;

  // Word address used for load/store overlap detection (byte offset ignored)
  function automatic logic [29:0] sb_word(input logic [31:0] addr);
    return addr[31:2];
  endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// rtl/sb_fwd_match.sv - youngest-match search of pending stores for load forwarding
module sb_fwd_match #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic [DEPTH-1:0][29:0] tags,
  input  logic [DEPTH-1:0][31:0] datas,
  input  logic [DEPTH-1:0]       valid,
  input  logic [PTR_W-1:0]       head,
  input  logic [29:0]            lookup,
  output logic                   hit,
  output logic [31:0]            data
);

  logic [PTR_W-1:0] idx;

  // Walk from oldest (head) to youngest; a later match overrides, so the youngest store wins
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (valid[idx] && (tags[idx] == lookup)) begin
        hit  = 1'b1;
        data = datas[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-store FIFO with drain/flush control; STORE_BUFFER_FWD_EN enables load forwarding
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic        Flush,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Empty,
  output logic        mem_wvalid,
  input  logic        mem_wready,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  sb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  sb_state_t        state;
  sb_state_t        state_next;
  logic             stall_int;
  logic             full;
  logic             enq;
  logic             deq;

  assign full       = (count == FULL_CNT);
  assign Empty      = (count == '0);
  // The head slot is valid exactly when at least one store is pending
  assign mem_wvalid = valid[head];
  assign mem_waddr  = mem_wvalid ? entries[head].addr : '0;
  assign mem_wdata  = mem_wvalid ? entries[head].data : '0;
  assign deq        = mem_wvalid & mem_wready;
  assign enq        = MemWrite & ~stall_int;
  assign Stall      = stall_int;

  // Next-state and stall decode; full-stall ignores mem_wready so Stall never depends on it
  always_comb begin
    state_next = state;
    stall_int  = 1'b0;
    case (state)
      RUN: begin
        if (Flush && (count != '0)) begin
          state_next = FLUSH;
        end
        stall_int = MemWrite & full;
`ifndef STORE_BUFFER_FWD_EN
        // Without forwarding a load must wait until every older store has reached memory
        if (MemRead && (count != '0)) begin
          stall_int = 1'b1;
        end
`endif
      end
      FLUSH: begin
        if (count == '0) begin
          state_next = RUN;
        end
        stall_int = MemWrite | MemRead;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // Control state: pointers, occupancy, valid bits and FSM register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
      state <= RUN;
    end else begin
      state <= state_next;
      if (enq) begin
        tail        <= tail + PTR_W'(1);
        valid[tail] <= 1'b1;
      end
      if (deq) begin
        head        <= head + PTR_W'(1);
        valid[head] <= 1'b0;
      end
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload storage; contents are only meaningful where the matching valid bit is set
  always_ff @(posedge clk) begin
    if (enq) begin
      entries[tail] <= '{addr: ALUResult, data: WriteData};
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  logic [DEPTH-1:0][29:0] tags;
  logic [DEPTH-1:0][31:0] datas;
  logic                   fwd_hit;
  logic [31:0]            fwd_data;

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign tags[i]  = sb_word(entries[i].addr);
    assign datas[i] = entries[i].data;
  end

  sb_fwd_match #(
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) u_fwd_match (
    .tags  (tags),
    .datas (datas),
    .valid (valid),
    .head  (head),
    .lookup(sb_word(ALUResult)),
    .hit   (fwd_hit),
    .data  (fwd_data)
  );

  // Lookup sees pre-enqueue contents, so a same-cycle store never forwards to its own load
  assign ReadData = (MemRead && fwd_hit) ? fwd_data : mem_rdata;
`else
  assign ReadData = mem_rdata;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - randomized and directed self-checking bench for store_buffer
module tb_store_buffer;

  localparam int DEPTH = 4;
`ifdef STORE_BUFFER_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite, MemRead, Flush, mem_wready;
  logic [31:0] ALUResult, WriteData, mem_rdata;
  logic [31:0] ReadData, mem_waddr, mem_wdata;
  logic        Stall, Empty, mem_wvalid;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  bit          m_flush = 1'b0;
  logic [31:0] store_order[$];
  logic [31:0] got_order[$];
  logic        last_stall;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .Flush     (Flush),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .Empty     (Empty),
    .mem_wvalid(mem_wvalid),
    .mem_wready(mem_wready),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Load result from the rules: youngest pending store to the same word, else memory
  function automatic logic [31:0] model_read();
    logic [31:0] r;
    r = mem_rdata;
    if (FWD && MemRead)
      for (int i = 0; i < mq.size(); i++)
        if (mq[i].addr[31:2] == ALUResult[31:2]) r = mq[i].data;
    return r;
  endfunction

  // One clock: check combinational outputs, cross the edge, advance the model
  task automatic cycle();
    int          cnt;
    logic        es;
    logic [31:0] ea, ed;
    cnt = mq.size();
    #1;
    if (m_flush) es = MemWrite | MemRead;
    else         es = (MemWrite && cnt == DEPTH) || (!FWD && MemRead && cnt > 0);
    ea = (cnt > 0) ? mq[0].addr : 32'h0;
    ed = (cnt > 0) ? mq[0].data : 32'h0;
    chk("mem_wvalid", 32'(mem_wvalid), 32'(cnt > 0));
    chk("Empty",      32'(Empty),      32'(cnt == 0));
    chk("Stall",      32'(Stall),      32'(es));
    chk("mem_waddr",  mem_waddr,       ea);
    chk("mem_wdata",  mem_wdata,       ed);
    chk("ReadData",   ReadData,        model_read());
    last_stall = Stall;
    if (mem_wvalid && mem_wready) got_order.push_back(mem_waddr);
    @(posedge clk);
    if (m_flush) begin
      if (cnt == 0) m_flush = 1'b0;
    end else if (Flush && cnt > 0) begin
      m_flush = 1'b1;
    end
    if (cnt > 0 && mem_wready) void'(mq.pop_front());
    if (MemWrite && !es) begin
      mq.push_back(ent_t'{addr: ALUResult, data: WriteData});
      store_order.push_back(ALUResult);
    end
    #1;
  endtask

  task automatic drive(input bit w, input bit r, input bit f, input bit rdy,
                       input logic [31:0] a, input logic [31:0] d);
    MemWrite   = w;
    MemRead    = r;
    Flush      = f;
    mem_wready = rdy;
    ALUResult  = a;
    WriteData  = d;
    mem_rdata  = $urandom;
    cycle();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2 && mq.size() > 0; i++) drive(0, 0, 0, 1, 32'h0, 32'h0);
    chk("drain_empty", 32'(mq.size()), 32'h0);
  endtask

  initial begin
    int stall_cycles;
    logic [31:0] a;

    reset = 1'b1; MemWrite = 0; MemRead = 0; Flush = 0; mem_wready = 0;
    ALUResult = 0; WriteData = 0; mem_rdata = 32'hcafe_f00d;
    #3;
    chk("rst_wvalid", 32'(mem_wvalid), 32'h0);
    chk("rst_stall",  32'(Stall),      32'h0);
    chk("rst_empty",  32'(Empty),      32'h1);
    chk("rst_waddr",  mem_waddr,       32'h0);
    chk("rst_wdata",  mem_wdata,       32'h0);
    chk("rst_rdata",  ReadData,        32'hcafe_f00d);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single store drains one cycle after acceptance
    drive(1, 0, 0, 1, 32'h10, 32'h2c);
    chk("one_waddr", mem_waddr, 32'h10);
    drive(0, 0, 0, 1, 32'h0, 32'h0);
    drive(0, 0, 0, 1, 32'h0, 32'h0);
    chk("one_empty", 32'(Empty), 32'h1);

    // Fill with memory blocked; fifth store stalls until a slot frees
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 32'h100 + 32'(i) * 4, $urandom);
    drive(1, 0, 0, 0, 32'h200, 32'h5555);
    chk("full_stall", 32'(last_stall), 32'h1);
    drive(1, 0, 0, 1, 32'h200, 32'h5555);
    chk("full_stall_rdy", 32'(last_stall), 32'h1);
    drive(1, 0, 0, 1, 32'h200, 32'h5555);
    chk("full_release", 32'(last_stall), 32'h0);
    drain();

    // Forwarding (or drain-before-load) with two stores to one word
    drive(1, 0, 0, 0, 32'h20, 32'h11);
    drive(1, 0, 0, 0, 32'h20, 32'h22);
    drive(0, 1, 0, 0, 32'h20, 32'h0);
    if (FWD) chk("fwd_young", ReadData, 32'h22);
    drive(0, 1, 0, 0, 32'h24, 32'h0);
    drive(0, 1, 0, 0, 32'h23, 32'h0);
    drive(1, 1, 0, 0, 32'h20, 32'h33);
    drain();

    // Flush with three pending: MemWrite stalls for exactly three cycles
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 32'h300 + 32'(i) * 4, $urandom);
    drive(0, 0, 1, 1, 32'h0, 32'h0);
    stall_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 1, 32'h400, 32'h44);
      if (!last_stall) break;
      stall_cycles++;
    end
    chk("flush_stalls", 32'(stall_cycles), 32'd3);
    drain();

    // Back-to-back store/drain pairs walk pointers through several wraps
    for (int i = 0; i < 6; i++) drive(1, 0, 0, 1, 32'h500 + 32'(i) * 4, $urandom);
    drain();

    // Randomized traffic on a small address pool so overlaps are common
    for (int i = 0; i < 300; i++) begin
      a = 32'h40 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) < 6), a, $urandom);
    end
    for (int i = 0; i < 12 && (mq.size() > 0 || m_flush); i++) drive(0, 0, 0, 1, 32'h0, 32'h0);
    chk("rand_drained", 32'(mq.size()), 32'h0);

    // Reset mid-drain discards pending stores immediately
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 32'h600 + 32'(i) * 4, $urandom);
    drive(0, 0, 0, 1, 32'h0, 32'h0);
    chk("pre_rst_cnt", 32'(mq.size()), 32'd2);
    MemWrite = 0; mem_wready = 1; reset = 1'b1;
    #1;
    chk("mid_rst_wvalid", 32'(mem_wvalid), 32'h0);
    chk("mid_rst_empty",  32'(Empty),      32'h1);
    chk("mid_rst_waddr",  mem_waddr,       32'h0);
    repeat (mq.size()) void'(store_order.pop_back());
    mq.delete();
    m_flush = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 32'h0, 32'h0);

    // Memory must have seen every accepted store, in program order
    chk("order_len", 32'(got_order.size()), 32'(store_order.size()));
    for (int i = 0; i < store_order.size() && i < got_order.size(); i++)
      chk("order_addr", got_order[i], store_order[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
